seg7_scan_driver_04: RTL and testbench

SEG7_SCAN_DRIVER_04 -- requirements
Module: seg7_scan_driver_04

---
 rtl/seg7_scan_driver_04.sv | 93 +++++++++
 tb/tb_seg7_scan_driver_04.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver_04.sv
// Six-digit multiplexed 7-segment driver for an HH.MM.SS clock display.
// Optional macro LZ_BLANK_EN blanks the hour tens digit when it is zero.
module seg7_scan_driver_04 #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk_04,
  input  logic       rst_04,
  input  logic [7:0] sec_04,
  input  logic [7:0] min_04,
  input  logic [7:0] hour_04,
  output logic [5:0] sel_04,
  output logic [6:0] seg_04,
  output logic       dp_04
);

  localparam logic [15:0] DivLast = 16'(SCAN_DIV - 1);

  logic [15:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] snap_q, snap_d;
  logic [5:0]  sel_q, sel_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        div_wrap;
  logic [3:0]  nib;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    div_wrap = (div_q == DivLast);
    div_d    = div_wrap ? 16'd0 : div_q + 16'd1;
    idx_d    = idx_q;
    if (div_wrap) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    // Snapshot only at the frame boundary so a frame never mixes old and new time.
    snap_d = (div_wrap && idx_q == 3'd5) ? {hour_04, min_04, sec_04} : snap_q;

    unique case (idx_q)
      3'd0:    nib = snap_q[3:0];
      3'd1:    nib = snap_q[7:4];
      3'd2:    nib = snap_q[11:8];
      3'd3:    nib = snap_q[15:12];
      3'd4:    nib = snap_q[19:16];
      3'd5:    nib = snap_q[23:20];
      default: nib = 4'd0;
    endcase

    sel_d = ~(6'd1 << idx_q);
    dp_d  = !(idx_q == 3'd2 || idx_q == 3'd4);
    seg_d = decode(nib);
`ifdef LZ_BLANK_EN
    if (idx_q == 3'd5 && nib == 4'd0) seg_d = 7'h7F;
`endif
  end

  always_ff @(posedge clk_04 or posedge rst_04) begin
    if (rst_04) begin
      div_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      sel_q  <= 6'h3F;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign sel_04 = sel_q;
  assign seg_04 = seg_q;
  assign dp_04  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver_04.sv
// Scoreboard bench for seg7_scan_driver_04 with SCAN_DIV=4; honours LZ_BLANK_EN.
module tb_seg7_scan_driver_04;

  localparam int unsigned Div = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sec = 8'h00, mnt = 8'h00, hour = 8'h00;
  logic [5:0] sel;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [2:0] slot;
    logic [6:0] seg;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] sel_q[$];
  logic [5:0] obs_sel[6];
  logic [6:0] obs_seg[6];
  logic       obs_dp[6];

  seg7_scan_driver_04 #(.SCAN_DIV(Div)) dut (
    .clk_04 (clk),
    .rst_04 (rst),
    .sec_04 (sec),
    .min_04 (mnt),
    .hour_04(hour),
    .sel_04 (sel),
    .seg_04 (seg),
    .dp_04  (dp)
  );

  always #5 clk = ~clk;

  // Returns at the first negedge on which slot 0 is shown after another slot.
  task automatic wait_frame_start();
    logic [5:0] prev;
    bit found;
    prev = sel;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (sel === 6'h3E && prev !== 6'h3E) found = 1;
      prev = sel;
    end
    if (!found) begin
      checks++;
      $display("FAIL frame_start timeout sel=%h", sel);
    end
  endtask

  task automatic capture_frame();
    wait_frame_start();
    for (int s = 0; s < 6; s++) begin
      if (s > 0) repeat (Div) @(negedge clk);
      obs_sel[s] = sel;
      obs_seg[s] = seg;
      obs_dp[s]  = dp;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (sel !== 6'h3F) $display("FAIL reset_sel got %h want 3f", sel); else passes++;
    checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", seg); else passes++;
    checks++; if (dp !== 1'b1) $display("FAIL reset_dp got %b want 1", dp); else passes++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (sel !== 6'h3E) $display("FAIL release_sel got %h want 3e", sel); else passes++;
    checks++; if (seg !== 7'h40) $display("FAIL release_seg got %h want 40", seg); else passes++;
  endtask

  task automatic test_scan();
    logic [5:0] cur, want;
    int run;
    sec = 8'h00; mnt = 8'h00; hour = 8'h00;
    sel_q = {6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};
    wait_frame_start();
    cur = sel;
    run = 1;
    want = sel_q.pop_front();
    checks++; if (cur !== want) $display("FAIL scan_sel got %h want %h", cur, want); else passes++;
    for (int i = 0; i < 60 && sel_q.size() > 0; i++) begin
      @(negedge clk);
      if (sel === cur) run++;
      else begin
        checks++;
        if (run != Div) $display("FAIL scan_hold sel %h held %0d want %0d", cur, run, Div);
        else passes++;
        want = sel_q.pop_front();
        checks++; if (sel !== want) $display("FAIL scan_sel got %h want %h", sel, want); else passes++;
        cur = sel;
        run = 1;
      end
    end
    if (sel_q.size() > 0) begin
      checks++;
      $display("FAIL scan_timeout got %0d left want 0", sel_q.size());
    end
  endtask

  task automatic test_decode();
    exp_t e;
    @(negedge clk);
    hour = 8'h23; mnt = 8'h59; sec = 8'h07;
    sb.push_back({3'd0, 7'h78}); sb.push_back({3'd1, 7'h40});
    sb.push_back({3'd2, 7'h10}); sb.push_back({3'd3, 7'h12});
    sb.push_back({3'd4, 7'h30}); sb.push_back({3'd5, 7'h24});
    capture_frame();
    capture_frame();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs_seg[e.slot] !== e.seg)
        $display("FAIL decode_seg slot%0d got %h want %h", e.slot, obs_seg[e.slot], e.seg);
      else passes++;
    end
    for (int s = 0; s < 6; s++) begin
      logic wdp;
      logic [5:0] wsel;
      wdp = (s == 2 || s == 4) ? 1'b0 : 1'b1;
      wsel = ~(6'd1 << s);
      checks++;
      if (obs_dp[s] !== wdp) $display("FAIL decode_dp slot%0d got %b want %b", s, obs_dp[s], wdp);
      else passes++;
      checks++;
      if (obs_sel[s] !== wsel) $display("FAIL decode_sel slot%0d got %h want %h", s, obs_sel[s], wsel);
      else passes++;
    end
  endtask

  task automatic test_tearing();
    exp_t e;
    wait_frame_start();
    repeat (3 * Div + 1) @(negedge clk);
    sec = 8'h08; hour = 8'h14;
    repeat (Div - 1) @(negedge clk);
    checks++; if (seg !== 7'h30) $display("FAIL tear_slot4 got %h want 30", seg); else passes++;
    repeat (Div) @(negedge clk);
    checks++; if (seg !== 7'h24) $display("FAIL tear_slot5 got %h want 24", seg); else passes++;
    sb.push_back({3'd0, 7'h00}); sb.push_back({3'd4, 7'h19}); sb.push_back({3'd5, 7'h79});
    capture_frame();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs_seg[e.slot] !== e.seg)
        $display("FAIL tear_next slot%0d got %h want %h", e.slot, obs_seg[e.slot], e.seg);
      else passes++;
    end
  endtask

  task automatic test_invalid();
    exp_t e;
    @(negedge clk);
    mnt = 8'hA5;
    sb.push_back({3'd2, 7'h12}); sb.push_back({3'd3, 7'h3F});
    capture_frame();
    capture_frame();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs_seg[e.slot] !== e.seg)
        $display("FAIL invalid slot%0d got %h want %h", e.slot, obs_seg[e.slot], e.seg);
      else passes++;
    end
  endtask

  task automatic test_lz();
    exp_t e;
    @(negedge clk);
    hour = 8'h09;
`ifdef LZ_BLANK_EN
    sb.push_back({3'd5, 7'h7F});
`else
    sb.push_back({3'd5, 7'h40});
`endif
    sb.push_back({3'd4, 7'h10});
    capture_frame();
    capture_frame();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs_seg[e.slot] !== e.seg)
        $display("FAIL lz slot%0d got %h want %h", e.slot, obs_seg[e.slot], e.seg);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    wait_frame_start();
    repeat (4 * Div) @(negedge clk);
    checks++; if (sel !== 6'h2F) $display("FAIL midrst_pre got %h want 2f", sel); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (sel !== 6'h3F) $display("FAIL midrst_sel got %h want 3f", sel); else passes++;
    checks++; if (seg !== 7'h7F) $display("FAIL midrst_seg got %h want 7f", seg); else passes++;
    checks++; if (dp !== 1'b1) $display("FAIL midrst_dp got %b want 1", dp); else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (sel !== 6'h3E) $display("FAIL midrst_rel_sel got %h want 3e", sel); else passes++;
    checks++; if (seg !== 7'h40) $display("FAIL midrst_rel_seg got %h want 40", seg); else passes++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_tearing();
    test_invalid();
    test_lz();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
